// File: rtl/sobel_frame_sequencer.sv
// Frame sequencer for the sobel_rgb_axis HLS core.
// Drives the core's ap_ctrl_hs block-level handshake for one frame or a burst
// of frames, inserts a fixed idle gap between frames, records the latency of
// the last frame, and guards every frame with a watchdog.
module sobel_frame_sequencer #(
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned WDOG_W     = 24,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic [CNT_W-1:0] cfg_frames,
    input  logic             cfg_abort,
    input  logic             cfg_clr_fault,
    output logic             core_ap_start,
    input  logic             core_ap_ready,
    input  logic             core_ap_done,
    output logic             busy,
    output logic             frame_done,
    output logic             run_done,
    output logic [CNT_W-1:0] frames_done,
    output logic [31:0]      last_latency,
    output logic             timeout_err
);

    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [GAP_W-1:0]  GAP_INIT = GAP_W'(GAP_LOAD);
    localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
    // Watchdog fires on the edge where the count would reach all-ones.
    localparam logic [WDOG_W-1:0] WD_LIMIT = {{(WDOG_W-1){1'b1}}, 1'b0};
    localparam logic [WDOG_W-1:0] WD_ONE   = WDOG_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        GAP,
        FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   frames_q, frames_d;
    logic [31:0]        lat_q, lat_d;
    logic [31:0]        last_lat_q, last_lat_d;
    logic [WDOG_W-1:0]  wd_q, wd_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               abort_q, abort_d;
    logic               frame_done_q, frame_done_d;
    logic               run_done_q, run_done_d;
    logic               timeout_q, timeout_d;

    logic               abort_now;
    logic               in_frame;
    logic               frame_fin;
    logic               run_last;

    // Next-state, counter and pulse logic for the frame sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        frames_d     = frames_q;
        lat_d        = lat_q;
        last_lat_d   = last_lat_q;
        wd_d         = wd_q;
        gap_d        = gap_q;
        abort_d      = abort_q;
        frame_done_d = 1'b0;
        run_done_d   = 1'b0;
        timeout_d    = timeout_q;
        frame_fin    = 1'b0;

        // An abort seen at any point of a frame is remembered until it ends.
        abort_now = abort_q | cfg_abort;
        in_frame  = (state_q == START) || (state_q == RUN);
        run_last  = abort_now ||
                    ((cnt_q != '0) && ((frames_q + CNT_ONE) == cnt_q));

        if (in_frame) begin
            wd_d    = wd_q + WD_ONE;
            lat_d   = (lat_q == '1) ? lat_q : lat_q + 32'd1;
            abort_d = abort_now;
        end

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    cnt_d    = cfg_frames;
                    frames_d = '0;
                    abort_d  = cfg_abort;
                    state_d  = START;
                    wd_d     = '0;
                    lat_d    = 32'd1;
                end
            end
            START: begin
                if (core_ap_ready && core_ap_done) begin
                    frame_fin = 1'b1;
                end else if (core_ap_ready) begin
                    state_d = RUN;
                end else if (wd_q == WD_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = FAULT;
                end
            end
            RUN: begin
                if (core_ap_done) begin
                    frame_fin = 1'b1;
                end else if (wd_q == WD_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = FAULT;
                end
            end
            GAP: begin
                if (abort_now) begin
                    run_done_d = 1'b1;
                    state_d    = IDLE;
                end else if (gap_q == '0) begin
                    state_d = START;
                    wd_d    = '0;
                    lat_d   = 32'd1;
                end else begin
                    gap_d = gap_q - GAP_ONE;
                end
            end
            FAULT: begin
                if (cfg_clr_fault) begin
                    timeout_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (frame_fin) begin
            frames_d     = frames_q + CNT_ONE;
            last_lat_d   = lat_q;
            frame_done_d = 1'b1;
            if (run_last) begin
                run_done_d = 1'b1;
                state_d    = IDLE;
            end else if (GAP_CYCLES == 0) begin
                state_d = START;
                wd_d    = '0;
                lat_d   = 32'd1;
            end else begin
                state_d = GAP;
                gap_d   = GAP_INIT;
            end
        end
    end

    // State and counter registers; reset clears everything immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            frames_q     <= '0;
            lat_q        <= '0;
            last_lat_q   <= '0;
            wd_q         <= '0;
            gap_q        <= '0;
            abort_q      <= 1'b0;
            frame_done_q <= 1'b0;
            run_done_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            frames_q     <= frames_d;
            lat_q        <= lat_d;
            last_lat_q   <= last_lat_d;
            wd_q         <= wd_d;
            gap_q        <= gap_d;
            abort_q      <= abort_d;
            frame_done_q <= frame_done_d;
            run_done_q   <= run_done_d;
            timeout_q    <= timeout_d;
        end
    end

    assign core_ap_start = (state_q == START);
    assign busy          = (state_q != IDLE);
    assign frame_done    = frame_done_q;
    assign run_done      = run_done_q;
    assign frames_done   = frames_q;
    assign last_latency  = last_lat_q;
    assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Directed bench for sobel_frame_sequencer with a small ap_ctrl_hs core model.
// Core model timing: the cycle in which ap_start first reads high is cycle 1;
// ready/done are asserted in cycle rdy_dly/done_dly of that numbering.
module tb_sobel_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic [3:0]  cfg_frames = '0;
    logic        cfg_abort = 1'b0;
    logic        cfg_clr_fault = 1'b0;
    logic        core_ap_ready = 1'b0;
    logic        core_ap_done = 1'b0;
    logic        core_ap_start;
    logic        busy;
    logic        frame_done;
    logic        run_done;
    logic [3:0]  frames_done;
    logic [31:0] last_latency;
    logic        timeout_err;

    int total = 0;
    int passed = 0;

    int rdy_dly = 0;
    int done_dly = 0;
    bit inj_done = 1'b0;
    int n_rise = 0, n_fd = 0, n_rd = 0;
    int start_len = 0, cur_len = 0;
    int cyc = 0, done_cyc = 0, k = 0;
    int gap_min = 1000, gap_max = 0;
    bit active = 1'b0, prev_start = 1'b0, have_done = 1'b0;

    always #5 clk = ~clk;

    sobel_frame_sequencer #(
        .GAP_CYCLES (4),
        .WDOG_W     (6),
        .CNT_W      (4)
    ) dut (
        .clock         (clk),
        .reset         (rst),
        .cfg_start     (cfg_start),
        .cfg_frames    (cfg_frames),
        .cfg_abort     (cfg_abort),
        .cfg_clr_fault (cfg_clr_fault),
        .core_ap_start (core_ap_start),
        .core_ap_ready (core_ap_ready),
        .core_ap_done  (core_ap_done),
        .busy          (busy),
        .frame_done    (frame_done),
        .run_done      (run_done),
        .frames_done   (frames_done),
        .last_latency  (last_latency),
        .timeout_err   (timeout_err)
    );

    // Core model and event monitor, evaluated on the falling edge.
    initial begin : core_model
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                active = 1'b0;
                prev_start = 1'b0;
                core_ap_ready = 1'b0;
                core_ap_done = 1'b0;
            end else begin
                core_ap_ready = 1'b0;
                core_ap_done = inj_done;
                inj_done = 1'b0;
                if (core_ap_start && !prev_start) begin
                    n_rise++;
                    active = 1'b1;
                    k = 1;
                    cur_len = 0;
                    if (have_done) begin
                        if (cyc - done_cyc - 1 < gap_min) gap_min = cyc - done_cyc - 1;
                        if (cyc - done_cyc - 1 > gap_max) gap_max = cyc - done_cyc - 1;
                    end
                end else if (active) begin
                    k++;
                end
                if (core_ap_start) begin
                    cur_len++;
                    start_len = cur_len;
                end
                prev_start = core_ap_start;
                if (active) begin
                    if (core_ap_start && k == rdy_dly) core_ap_ready = 1'b1;
                    if (done_dly != 0 && k == done_dly) begin
                        core_ap_done = 1'b1;
                        active = 1'b0;
                    end
                end
                if (core_ap_done) begin
                    done_cyc = cyc;
                    have_done = 1'b1;
                end
                if (frame_done) n_fd++;
                if (run_done) n_rd++;
            end
        end
    end

    initial begin : global_limit
        #200000;
        $display("FAIL global_limit: simulation time budget exhausted");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic start_run(input logic [3:0] n, input int r, input int d);
        rdy_dly = r;
        done_dly = d;
        cfg_frames = n;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    // sel: 0 = run_done pulses, 1 = frame_done pulses, 2 = ap_start rises
    task automatic wait_until(input int sel, input int target, input int budget, output bit ok);
        int v;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            v = (sel == 0) ? n_rd : (sel == 1) ? n_fd : n_rise;
            if (v >= target) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset;
        #1;
        total++; if ({core_ap_start, busy, frame_done, run_done, timeout_err} !== 5'b0) $display("FAIL reset.flags got %b want 00000", {core_ap_start, busy, frame_done, run_done, timeout_err}); else passed++;
        total++; if (frames_done !== 4'd0) $display("FAIL reset.frames_done got %0d want 0", frames_done); else passed++;
        total++; if (last_latency !== 32'd0) $display("FAIL reset.last_latency got %0d want 0", last_latency); else passed++;
        repeat (3) step();
        rst = 1'b0;
        step();
        total++; if (busy !== 1'b0) $display("FAIL reset.busy_after_release got %b want 0", busy); else passed++;
    endtask

    task automatic test_single_frame;
        int r0, f0, d0;
        bit ok;
        r0 = n_rise; f0 = n_fd; d0 = n_rd;
        start_run(4'd1, 3, 20);
        total++; if (core_ap_start !== 1'b1 || busy !== 1'b1) $display("FAIL single.start got start=%b busy=%b want 1 1", core_ap_start, busy); else passed++;
        wait_until(0, d0 + 1, 100, ok);
        total++; if (!ok) $display("FAIL single.run_done_wait got none want pulse"); else passed++;
        step();
        total++; if (n_rise - r0 !== 1) $display("FAIL single.rises got %0d want 1", n_rise - r0); else passed++;
        total++; if (start_len !== 3) $display("FAIL single.start_len got %0d want 3", start_len); else passed++;
        total++; if (n_fd - f0 !== 1 || n_rd - d0 !== 1) $display("FAIL single.pulses got fd=%0d rd=%0d want 1 1", n_fd - f0, n_rd - d0); else passed++;
        total++; if (frames_done !== 4'd1) $display("FAIL single.frames_done got %0d want 1", frames_done); else passed++;
        total++; if (last_latency !== 32'd20) $display("FAIL single.last_latency got %0d want 20", last_latency); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL single.busy_end got %b want 0", busy); else passed++;
    endtask

    task automatic test_burst;
        int r0, d0;
        bit ok;
        r0 = n_rise; d0 = n_rd;
        have_done = 1'b0; gap_min = 1000; gap_max = 0;
        start_run(4'd3, 2, 6);
        wait_until(0, d0 + 1, 200, ok);
        total++; if (!ok) $display("FAIL burst.run_done_wait got none want pulse"); else passed++;
        repeat (10) step();
        total++; if (n_rise - r0 !== 3) $display("FAIL burst.rises got %0d want 3", n_rise - r0); else passed++;
        total++; if (gap_min !== 4 || gap_max !== 4) $display("FAIL burst.gap got min=%0d max=%0d want 4 4", gap_min, gap_max); else passed++;
        total++; if (frames_done !== 4'd3) $display("FAIL burst.frames_done got %0d want 3", frames_done); else passed++;
        total++; if (n_rd - d0 !== 1) $display("FAIL burst.run_done_count got %0d want 1", n_rd - d0); else passed++;
        total++; if (last_latency !== 32'd6) $display("FAIL burst.last_latency got %0d want 6", last_latency); else passed++;
    endtask

    task automatic test_ready_done_same;
        int r0, f0, d0;
        bit ok;
        r0 = n_rise; f0 = n_fd; d0 = n_rd;
        start_run(4'd1, 4, 4);
        wait_until(0, d0 + 1, 100, ok);
        total++; if (!ok) $display("FAIL same.run_done_wait got none want pulse"); else passed++;
        repeat (12) step();
        total++; if (n_rise - r0 !== 1) $display("FAIL same.rises got %0d want 1", n_rise - r0); else passed++;
        total++; if (start_len !== 4) $display("FAIL same.start_len got %0d want 4", start_len); else passed++;
        total++; if (n_fd - f0 !== 1 || frames_done !== 4'd1) $display("FAIL same.count got fd=%0d frames=%0d want 1 1", n_fd - f0, frames_done); else passed++;
        total++; if (last_latency !== 32'd4) $display("FAIL same.last_latency got %0d want 4", last_latency); else passed++;
    endtask

    task automatic test_abort_in_start;
        int r0, f0, d0;
        bit ok;
        r0 = n_rise; f0 = n_fd; d0 = n_rd;
        start_run(4'd0, 3, 8);
        wait_until(2, r0 + 2, 60, ok);
        total++; if (!ok || core_ap_start !== 1'b1) $display("FAIL abort.second_start got ok=%b start=%b want 1 1", ok, core_ap_start); else passed++;
        cfg_abort = 1'b1;
        step();
        total++; if (core_ap_start !== 1'b1) $display("FAIL abort.start_held got %b want 1", core_ap_start); else passed++;
        wait_until(0, d0 + 1, 60, ok);
        total++; if (!ok) $display("FAIL abort.run_done_wait got none want pulse"); else passed++;
        repeat (15) step();
        cfg_abort = 1'b0;
        total++; if (start_len !== 3) $display("FAIL abort.start_len got %0d want 3", start_len); else passed++;
        total++; if (n_rise - r0 !== 2) $display("FAIL abort.rises got %0d want 2", n_rise - r0); else passed++;
        total++; if (frames_done !== 4'd2 || n_fd - f0 !== 2) $display("FAIL abort.frames got frames=%0d fd=%0d want 2 2", frames_done, n_fd - f0); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL abort.busy_end got %b want 0", busy); else passed++;
    endtask

    task automatic test_watchdog;
        int r0, f0;
        r0 = n_rise; f0 = n_fd;
        start_run(4'd1, 0, 0);
        repeat (62) step();
        total++; if (timeout_err !== 1'b0 || core_ap_start !== 1'b1) $display("FAIL wdog.before got err=%b start=%b want 0 1", timeout_err, core_ap_start); else passed++;
        step();
        total++; if (timeout_err !== 1'b1 || core_ap_start !== 1'b0 || busy !== 1'b1) $display("FAIL wdog.expiry got err=%b start=%b busy=%b want 1 0 1", timeout_err, core_ap_start, busy); else passed++;
        inj_done = 1'b1;
        repeat (3) step();
        total++; if (frames_done !== 4'd0 || n_fd !== f0) $display("FAIL wdog.late_done got frames=%0d fd=%0d want 0 %0d", frames_done, n_fd, f0); else passed++;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        repeat (3) step();
        total++; if (n_rise - r0 !== 1 || busy !== 1'b1 || timeout_err !== 1'b1) $display("FAIL wdog.start_ignored got rises=%0d busy=%b err=%b want 1 1 1", n_rise - r0, busy, timeout_err); else passed++;
        cfg_clr_fault = 1'b1;
        step();
        cfg_clr_fault = 1'b0;
        total++; if (busy !== 1'b0 || timeout_err !== 1'b0) $display("FAIL wdog.clear got busy=%b err=%b want 0 0", busy, timeout_err); else passed++;
    endtask

    task automatic test_wrap_and_gap_abort;
        int r0, f0, d0;
        bit ok;
        r0 = n_rise; f0 = n_fd; d0 = n_rd;
        start_run(4'd0, 1, 2);
        wait_until(1, f0 + 17, 300, ok);
        total++; if (!ok) $display("FAIL wrap.frame_wait got %0d want 17", n_fd - f0); else passed++;
        cfg_abort = 1'b1;
        wait_until(0, d0 + 1, 20, ok);
        cfg_abort = 1'b0;
        total++; if (!ok) $display("FAIL wrap.run_done_wait got none want pulse"); else passed++;
        repeat (10) step();
        total++; if (frames_done !== 4'd1) $display("FAIL wrap.frames_done got %0d want 1", frames_done); else passed++;
        total++; if (n_rise - r0 !== 17) $display("FAIL wrap.rises got %0d want 17", n_rise - r0); else passed++;
    endtask

    task automatic test_reset_mid_run;
        int d0;
        bit ok;
        start_run(4'd1, 2, 30);
        repeat (10) step();
        rst = 1'b1;
        #1;
        total++; if (core_ap_start !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) $display("FAIL rstmid.flags got start=%b busy=%b err=%b want 0 0 0", core_ap_start, busy, timeout_err); else passed++;
        total++; if (last_latency !== 32'd0 || frames_done !== 4'd0) $display("FAIL rstmid.counters got lat=%0d frames=%0d want 0 0", last_latency, frames_done); else passed++;
        step();
        rst = 1'b0;
        step();
        d0 = n_rd;
        start_run(4'd1, 3, 5);
        wait_until(0, d0 + 1, 60, ok);
        total++; if (!ok) $display("FAIL rstmid.run_done_wait got none want pulse"); else passed++;
        step();
        total++; if (frames_done !== 4'd1 || last_latency !== 32'd5) $display("FAIL rstmid.rerun got frames=%0d lat=%0d want 1 5", frames_done, last_latency); else passed++;
    endtask

    initial begin : main
        test_reset();
        test_single_frame();
        test_burst();
        test_ready_done_same();
        test_abort_in_start();
        test_watchdog();
        test_wrap_and_gap_abort();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
